// File: rtl/id_exe_pipe_ctrl.sv
// id_exe_pipe_ctrl
//   ID/EXE pipeline register with a per-stage valid bit, an external hold,
//   a branch flush and load-use hazard detection with automatic bubble
//   insertion.
//
//   Optional feature macro: ID_EXE_PERF_EN
//     When defined, two CW-bit saturating counters are added.
//     bubble_cnt_out counts hazard bubbles.
//     flush_cnt_out counts flushed edges.
//
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   stall_in                  external hold; EXE contents frozen
//   flush_in                  branch taken; squash the instruction entering EXE
//   id_valid_in               ID holds a real instruction
//   rs1_in, rs2_in            source register addresses of the ID instruction
//   rdata1_in .. npc_in       operands and control bits of the ID instruction
//   exe_valid_out .. npc_out  registered copies of the ID fields
//   hazard_stall_out          combinational load-use detect; IF/ID must hold
//   bubble_cnt_out,
//   flush_cnt_out             performance counters (ID_EXE_PERF_EN only)

module id_exe_pipe_ctrl #(
  parameter int DW  = 16,
  parameter int AW  = 3,
  parameter int PW  = 16,
  parameter int OPW = 3,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall_in,
  input  logic           flush_in,
  input  logic           id_valid_in,
  input  logic [AW-1:0]  rs1_in,
  input  logic [AW-1:0]  rs2_in,
  input  logic [DW-1:0]  rdata1_in,
  input  logic [DW-1:0]  rdata2_in,
  input  logic [DW-1:0]  imm_in,
  input  logic [OPW-1:0] opcode_in,
  input  logic [AW-1:0]  waddr_in,
  input  logic           alusrc_in,
  input  logic           memWrite_in,
  input  logic           memRead_in,
  input  logic           memToReg_in,
  input  logic           branch_in,
  input  logic           wen_in,
  input  logic [PW-1:0]  npc_in,
  output logic           exe_valid_out,
  output logic [DW-1:0]  rdata1_out,
  output logic [DW-1:0]  rdata2_out,
  output logic [DW-1:0]  imm_out,
  output logic [OPW-1:0] opcode_out,
  output logic [AW-1:0]  waddr_out,
  output logic           alusrc_out,
  output logic           memWrite_out,
  output logic           memRead_out,
  output logic           memToReg_out,
  output logic           branch_out,
  output logic           wen_out,
  output logic [PW-1:0]  npc_out,
  output logic           hazard_stall_out
`ifdef ID_EXE_PERF_EN
  ,
  output logic [CW-1:0]  bubble_cnt_out,
  output logic [CW-1:0]  flush_cnt_out
`endif
);

  typedef enum logic [1:0] {
    LD_LOAD,
    LD_BUBBLE,
    LD_HOLD
  } ld_sel_e;

  ld_sel_e        ldSel;
  logic           hazard;

  logic           valid_q,    valid_d;
  logic [DW-1:0]  rdata1_q,   rdata1_d;
  logic [DW-1:0]  rdata2_q,   rdata2_d;
  logic [DW-1:0]  imm_q,      imm_d;
  logic [OPW-1:0] opcode_q,   opcode_d;
  logic [AW-1:0]  waddr_q,    waddr_d;
  logic           alusrc_q,   alusrc_d;
  logic           memWrite_q, memWrite_d;
  logic           memRead_q,  memRead_d;
  logic           memToReg_q, memToReg_d;
  logic           branch_q,   branch_d;
  logic           wen_q,      wen_d;
  logic [PW-1:0]  npc_q,      npc_d;

  // Load-use detect: a valid load in EXE writing a nonzero register that the
  // valid ID instruction reads. Register 0 is hardwired, so it never stalls.
  always_comb begin
    hazard = valid_q & memRead_q & wen_q & (waddr_q != '0) & id_valid_in &
             ((rs1_in == waddr_q) | (rs2_in == waddr_q));
  end

  // Update selection: flush beats the external hold, and the hold beats the
  // hazard bubble so a stalled load-use pair keeps hazard_stall_out high.
  always_comb begin
    ldSel = LD_LOAD;
    if (flush_in) begin
      ldSel = LD_BUBBLE;
    end else if (stall_in) begin
      ldSel = LD_HOLD;
    end else if (hazard) begin
      ldSel = LD_BUBBLE;
    end
  end

  // Next-state values for the whole register. A bubble clears every field,
  // which also makes it indistinguishable from the reset state.
  always_comb begin
    valid_d    = valid_q;
    rdata1_d   = rdata1_q;
    rdata2_d   = rdata2_q;
    imm_d      = imm_q;
    opcode_d   = opcode_q;
    waddr_d    = waddr_q;
    alusrc_d   = alusrc_q;
    memWrite_d = memWrite_q;
    memRead_d  = memRead_q;
    memToReg_d = memToReg_q;
    branch_d   = branch_q;
    wen_d      = wen_q;
    npc_d      = npc_q;
    case (ldSel)
      LD_LOAD: begin
        valid_d    = id_valid_in;
        rdata1_d   = rdata1_in;
        rdata2_d   = rdata2_in;
        imm_d      = imm_in;
        opcode_d   = opcode_in;
        waddr_d    = waddr_in;
        alusrc_d   = alusrc_in;
        memWrite_d = memWrite_in;
        memRead_d  = memRead_in;
        memToReg_d = memToReg_in;
        branch_d   = branch_in;
        wen_d      = wen_in;
        npc_d      = npc_in;
      end
      LD_BUBBLE: begin
        valid_d    = 1'b0;
        rdata1_d   = '0;
        rdata2_d   = '0;
        imm_d      = '0;
        opcode_d   = '0;
        waddr_d    = '0;
        alusrc_d   = 1'b0;
        memWrite_d = 1'b0;
        memRead_d  = 1'b0;
        memToReg_d = 1'b0;
        branch_d   = 1'b0;
        wen_d      = 1'b0;
        npc_d      = '0;
      end
      default: begin
      end
    endcase
  end

  // Pipeline register; reset acts immediately, even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rdata1_q   <= '0;
      rdata2_q   <= '0;
      imm_q      <= '0;
      opcode_q   <= '0;
      waddr_q    <= '0;
      alusrc_q   <= 1'b0;
      memWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      memToReg_q <= 1'b0;
      branch_q   <= 1'b0;
      wen_q      <= 1'b0;
      npc_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rdata1_q   <= rdata1_d;
      rdata2_q   <= rdata2_d;
      imm_q      <= imm_d;
      opcode_q   <= opcode_d;
      waddr_q    <= waddr_d;
      alusrc_q   <= alusrc_d;
      memWrite_q <= memWrite_d;
      memRead_q  <= memRead_d;
      memToReg_q <= memToReg_d;
      branch_q   <= branch_d;
      wen_q      <= wen_d;
      npc_q      <= npc_d;
    end
  end

  assign exe_valid_out    = valid_q;
  assign rdata1_out       = rdata1_q;
  assign rdata2_out       = rdata2_q;
  assign imm_out          = imm_q;
  assign opcode_out       = opcode_q;
  assign waddr_out        = waddr_q;
  assign alusrc_out       = alusrc_q;
  assign memWrite_out     = memWrite_q;
  assign memRead_out      = memRead_q;
  assign memToReg_out     = memToReg_q;
  assign branch_out       = branch_q;
  assign wen_out          = wen_q;
  assign npc_out          = npc_q;
  assign hazard_stall_out = hazard;

`ifdef ID_EXE_PERF_EN
  logic [CW-1:0] bubbleCnt_q;
  logic [CW-1:0] flushCnt_q;

  // Saturating counters. A flush that coincides with a hazard counts only as
  // a flush, and a stalled hazard inserts no bubble, so it is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubbleCnt_q <= '0;
      flushCnt_q  <= '0;
    end else begin
      if (flush_in && !(&flushCnt_q)) begin
        flushCnt_q <= flushCnt_q + CW'(1);
      end
      if (!flush_in && (ldSel == LD_BUBBLE) && !(&bubbleCnt_q)) begin
        bubbleCnt_q <= bubbleCnt_q + CW'(1);
      end
    end
  end

  assign bubble_cnt_out = bubbleCnt_q;
  assign flush_cnt_out  = flushCnt_q;
`endif

endmodule

// File: doc/id_exe_pipe_ctrl.md
# id_exe_pipe_ctrl

- Parametrised ID/EXE pipeline register with built-in hazard handling.
- Sits between decode and execute and replaces the fixed-width, always-loading register.
- Adds a per-stage valid bit, an external hold, a branch flush, and load-use hazard detection with automatic bubble insertion.
- Optionally counts inserted bubbles and flushes for performance analysis.

## Interface
Parameters:
- DW, 16, data/immediate width
- AW, 3, register address width
- PW, 16, next-PC width
- OPW, 3, opcode width
- CW, 16, performance counter width (used only with the macro)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  one clock; reset is asynchronous and active-high
- stall_in  in  1  external hold (e.g. memory wait); EXE contents frozen
- flush_in  in  1  branch taken; squash the instruction entering EXE
- id_valid_in  in  1  ID holds a real instruction
- rs1_in, rs2_in  in  AW  source register addresses of the ID instruction
- rdata1_in, rdata2_in, imm_in  in  DW  operands / immediate
- opcode_in  in  OPW  ALU opcode
- waddr_in  in  AW  destination register
- alusrc_in, memWrite_in, memRead_in, memToReg_in, branch_in, wen_in  in  1  control bits
- npc_in  in  PW  next PC
- Registered outputs, named `*_out`, one for each input above except rs1/rs2: exe_valid_out, rdata1_out, rdata2_out, imm_out, opcode_out, waddr_out, alusrc_out, memWrite_out, memRead_out, memToReg_out, branch_out, wen_out, npc_out
- hazard_stall_out  out  1  combinational load-use detect; upstream IF/ID must hold while high
- bubble_cnt_out, flush_cnt_out  out  CW  present only with ID_EXE_PERF_EN

## Operation
- Every output register has a single update rule. Priority is highest first:
  1. rst: all outputs 0, exe_valid_out=0. Asynchronous, takes effect immediately, including mid-stall.
  2. flush_in: load a bubble.
  3. stall_in: hold all registers. Flush still overrides the hold.
  4. hazard_stall_out: load a bubble.
  5. Otherwise: load all inputs; exe_valid_out <= id_valid_in.
- Bubble definition:
  - exe_valid_out=0.
  - memWrite, memRead, memToReg, branch and wen outputs = 0.
  - All data, opcode, waddr and npc fields = 0.
- hazard_stall_out = exe_valid_out & memRead_out & wen_out & (waddr_out != 0) & id_valid_in & ((rs1_in == waddr_out) | (rs2_in == waddr_out)).
  - Register 0 never causes a hazard.
  - Purely combinational from registered state and ID inputs; no state machine.
- Invalid ID instruction (id_valid_in=0):
  - Fields are loaded as presented; only exe_valid_out gates downstream effects.
  - Downstream must qualify wen/memWrite with exe_valid_out.
- Simultaneous events:
  - flush+stall: flush wins.
  - flush+hazard: bubble, counted as a flush only.
  - stall+hazard: hold; hazard_stall_out stays high and the bubble is not counted.

## Timing
- Latency: 1 cycle from input to `*_out` on a normal load.
- hazard_stall_out is valid in the same cycle as the ID inputs. It must settle before the IF/ID enable.
- A load-use pair costs exactly 1 bubble cycle:
  - hazard_stall_out is high for one cycle.
  - Next cycle the load has left EXE, so the hazard drops and the dependent instruction loads.
- Reset deassertion: the first rising edge afterwards performs a normal load.

## Configuration
- ID_EXE_PERF_EN defined: two CW-bit saturating counters.
  - bubble_cnt_out increments on each edge where a hazard bubble is loaded.
  - flush_cnt_out increments on each flushed edge.
  - Both hold at all-ones. Both reset to 0 on rst.
- ID_EXE_PERF_EN undefined: counters and both ports are absent; behaviour is otherwise identical.

## Test plan
- Reset mid-stream: rst pulse during stall_in=1 with outputs nonzero -> all outputs 0 immediately, before the next edge; exe_valid_out=0.
- Normal flow: id_valid_in=1, rdata1_in=0x1234, opcode_in=3, wen_in=1 -> next edge rdata1_out=0x1234, opcode_out=3, wen_out=1, exe_valid_out=1.
- Load-use hazard:
  - Stimulus: EXE holds a valid load with waddr_out=5; ID presents rs2_in=5.
  - Response: hazard_stall_out=1.
  - Next edge: exe_valid_out=0, memRead_out=0, and (with macro) bubble_cnt_out=1.
  - Following cycle: hazard_stall_out=0 and the instruction loads.
- Hazard exemptions: as above but waddr_out=0, or memRead_out=0 -> hazard_stall_out=0 and normal load.
- Stall/flush priority:
  - stall_in=1 for 3 edges -> outputs unchanged.
  - stall_in=1 with flush_in=1 -> bubble loaded and flush_cnt_out=1.
- Counter saturation: CW=2 with 5 flushes -> flush_cnt_out=3.
